csr_dosyasi: RTL and testbench
==============================

// Module: csr_dosyasi
// PURPOSE
//  Machine-mode CSR register file. Responder side of the CSR access interface:
//  decodes the 12-bit address to a csr_yazilabilir_hedef_t target and performs CSRRW/RS/RC.
//  Also maintains the cycle/instret counters, FPU flag and FS tracking, and trap/mret state.
//  Sits beside the execute stage; exports mtvec/mepc/frm/fs to fetch, trap logic and FPU.
// PARAMETERS
//  MISA_DEGER   32'h40001124  read-only misa value (RV32IMFC)
//  MTVEC_RESET  32'h0         mtvec reset value, bits[1:0] forced 0
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   reset: synchronous, active-high
//  istek_gecerli_i    in   1   CSR request valid
//  istek_hazir_o      out  1   request accepted when valid & hazir
//  istek_islem_i      in   2   csr_islem_t: 01 RW, 10 RS, 11 RC (00 treated as read)
//  istek_adres_i      in   12  CSR address
//  istek_veri_i       in   32  rs1/imm operand
//  yanit_gecerli_o    out  1   response valid
//  yanit_hazir_i      in   1   response consumed when gecerli & hazir
//  yanit_veri_o       out  32  old CSR value
//  yanit_hata_o       out  1   illegal address
//  emekli_i           in   1   instruction retired this cycle
//  fpu_bayrak_gecerli_i in 1   accumulate fpu_bayrak_i into fflags
//  fpu_bayrak_i       in   5   NV,DZ,OF,UF,NX
//  fp_kirlet_i        in   1   FP register written: FS <- FS_KIRLI
//  istisna_i          in   1   trap entry
//  istisna_pc_i       in   32  PC written to mepc
//  istisna_neden_i    in   32  value written to mcause
//  istisna_deger_i    in   32  value written to mtval
//  mret_i             in   1   mret commit
//  mtvec_o / mepc_o   out  32  current register values
//  frm_o              out  3   rounding mode
//  fs_o               out  2   fs_t_deger(FS)
// BEHAVIOUR
//  - FSM BOSTA/YANIT. istek_hazir_o = BOSTA & !istisna_i & !mret_i & !rst_i.
//    Accept -> read old value, commit write on the same edge -> YANIT next cycle.
//    YANIT holds the output stable until yanit_hazir_i, then -> BOSTA.
//  - Latency: response is valid the cycle after acceptance. Back-to-back throughput is
//    one request per 2 cycles.
//  - Write value: RW = veri; RS = old|veri; RC = old&~veri. RS/RC with veri==0 perform
//    no write.
//  - Illegal target (CSR_GECERSIZ_HEDEF): no write, yanit_hata_o=1, yanit_veri_o=0.
//  - Field masks:
//    - misa/mstatush: read-only, writes ignored without error.
//    - mtvec: [1:0]=0. mepc: [0]=0. mie: mask 32'h888. mcountinhibit: bits 0,2 only.
//    - mstatus: MIE[3], MPIE[7], MPP[12:11] fixed 2'b11, FS[14:13] via deger_fs_t
//      (01/10 -> 00), SD[31] = (FS==11).
//    - fcsr = {24'b0, frm, fflags}.
//  - Writes to fcsr/frm/fflags set FS dirty.
//  - mcycle: +1 per cycle unless mcountinhibit[0]. minstret: +1 on emekli_i unless
//    mcountinhibit[2]. 64-bit wrap-around to 0.
//    A CSR write to either half in the same cycle wins; that counter does not increment.
//  - fflags accumulate: new = (write ? wdata : old) | fpu_bayrak_i. Flag bits are never lost.
//  - istisna_i:
//    - mepc<=pc&~1, mcause<=neden, mtval<=deger, MPIE<=MIE, MIE<=0.
//    - Priority over mret_i; requests are blocked that cycle.
//  - mret_i: MIE<=MPIE, MPIE<=1.
//  - Reset:
//    - Outputs: istek_hazir_o=0, yanit_gecerli_o=0, yanit_veri_o=0, yanit_hata_o=0,
//      mtvec_o=MTVEC_RESET, mepc_o=0, frm_o=0, fs_o=00.
//    - Internal: all CSRs 0 except mstatus.MPP=11 and mtvec. FSM -> BOSTA.
//    - Reset asserted during YANIT drops the response.
// CONFIGURATION
//  CSR_SAYACLAR_EN defined: mcycle/minstret (+H halves) are implemented as above.
//  Undefined: these addresses still decode as legal, read 0, writes are ignored, and no
//  counter flops are generated.
// STRUCTURE
//  csr_pkg gains:
//    - csr_islem_t enum.
//    - mstatus bit-position localparams (MSTATUS_MIE=3, MPIE=7, FS_LSB=13, SD=31).
//    - MIE_MASKE.
//  Sub-module csr_sayac: 64-bit counter with inhibit, increment enable, and low/high half
//  write ports. It is instantiated twice.
// TESTING
//  1. Reset; CSRRW mscratch veri=32'hDEADBEEF -> resp 0; then CSRRS veri=0 -> resp DEADBEEF,
//     no write.
//  2. CSRRW 12'h7FF -> yanit_hata_o=1, data 0; hold yanit_hazir_i=0 3 cycles -> output
//     stable, hazir_o=0.
//  3. mcycle write 32'hFFFFFFFF with mcycleh=0 -> after 1 cycle mcycleh=1, mcycle=0;
//     mcountinhibit=1 -> frozen.
//  4. fflags RW 5'b00001 with fpu_bayrak_i=5'b10000 same cycle -> fflags=5'b10001,
//     fs_o=2'b11, mstatus[31]=1.
//  5. MIE=1, istisna_i pc=32'h103 neden=2 with request valid -> request not accepted,
//     mepc=32'h102, MIE=0, MPIE=1; mret -> MIE=1.
//  6. Write mstatus FS=2'b01 -> fs_o=00; write mtvec 32'h80000003 -> mtvec_o=32'h80000000.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared types, mstatus field positions and address decode for the CSR file
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OKU = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_islem_t;

  typedef enum logic [4:0] {
    CSR_GECERSIZ_HEDEF,
    CSR_FFLAGS_HEDEF,
    CSR_FRM_HEDEF,
    CSR_FCSR_HEDEF,
    CSR_MSTATUS_HEDEF,
    CSR_MISA_HEDEF,
    CSR_MIE_HEDEF,
    CSR_MTVEC_HEDEF,
    CSR_MSTATUSH_HEDEF,
    CSR_MCOUNTINHIBIT_HEDEF,
    CSR_MSCRATCH_HEDEF,
    CSR_MEPC_HEDEF,
    CSR_MCAUSE_HEDEF,
    CSR_MTVAL_HEDEF,
    CSR_MCYCLE_HEDEF,
    CSR_MCYCLEH_HEDEF,
    CSR_MINSTRET_HEDEF,
    CSR_MINSTRETH_HEDEF
  } csr_yazilabilir_hedef_t;

  typedef enum logic [1:0] {
    FS_KAPALI = 2'b00,
    FS_ILK    = 2'b01,
    FS_TEMIZ  = 2'b10,
    FS_KIRLI  = 2'b11
  } fs_t;

  localparam int MSTATUS_MIE     = 3;
  localparam int MSTATUS_MPIE    = 7;
  localparam int MSTATUS_MPP_LSB = 11;
  localparam int MSTATUS_FS_LSB  = 13;
  localparam int MSTATUS_SD      = 31;

  localparam logic [31:0] MIE_MASKE           = 32'h0000_0888;
  localparam logic [31:0] MCOUNTINHIBIT_MASKE = 32'h0000_0005;

  // Only Off and Dirty are tracked; Initial/Clean collapse to Off.
  function automatic fs_t deger_fs_t(input logic [1:0] deger);
    return (deger == 2'b11) ? FS_KIRLI : FS_KAPALI;
  endfunction

  function automatic logic [1:0] fs_t_deger(input fs_t fs);
    return fs;
  endfunction

  function automatic csr_yazilabilir_hedef_t csr_hedef_coz(input logic [11:0] adres);
    case (adres)
      12'h001: return CSR_FFLAGS_HEDEF;
      12'h002: return CSR_FRM_HEDEF;
      12'h003: return CSR_FCSR_HEDEF;
      12'h300: return CSR_MSTATUS_HEDEF;
      12'h301: return CSR_MISA_HEDEF;
      12'h304: return CSR_MIE_HEDEF;
      12'h305: return CSR_MTVEC_HEDEF;
      12'h310: return CSR_MSTATUSH_HEDEF;
      12'h320: return CSR_MCOUNTINHIBIT_HEDEF;
      12'h340: return CSR_MSCRATCH_HEDEF;
      12'h341: return CSR_MEPC_HEDEF;
      12'h342: return CSR_MCAUSE_HEDEF;
      12'h343: return CSR_MTVAL_HEDEF;
      12'hB00: return CSR_MCYCLE_HEDEF;
      12'hB80: return CSR_MCYCLEH_HEDEF;
      12'hB02: return CSR_MINSTRET_HEDEF;
      12'hB82: return CSR_MINSTRETH_HEDEF;
      default: return CSR_GECERSIZ_HEDEF;
    endcase
  endfunction

endpackage

// File: rtl/csr_sayac.sv
// rtl/csr_sayac.sv - 64-bit counter with inhibit, increment enable and per-half write ports
module csr_sayac (
  input  logic        clk,
  input  logic        rst,
  input  logic        durdur,
  input  logic        artir,
  input  logic        yaz_alt,
  input  logic        yaz_ust,
  input  logic [31:0] yaz_veri,
  output logic [63:0] deger
);

  // A software write to either half takes precedence over counting in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      deger <= '0;
    end else if (yaz_alt) begin
      deger[31:0] <= yaz_veri;
    end else if (yaz_ust) begin
      deger[63:32] <= yaz_veri;
    end else if (artir && !durdur) begin
      deger <= deger + 64'd1;
    end
  end

endmodule

// File: rtl/csr_dosyasi.sv
// rtl/csr_dosyasi.sv - machine-mode CSR file; CSR_SAYACLAR_EN enables the mcycle/minstret counters
module csr_dosyasi
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_DEGER  = 32'h4000_1124,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek_gecerli_i,
  output logic        istek_hazir_o,
  input  logic [1:0]  istek_islem_i,
  input  logic [11:0] istek_adres_i,
  input  logic [31:0] istek_veri_i,
  output logic        yanit_gecerli_o,
  input  logic        yanit_hazir_i,
  output logic [31:0] yanit_veri_o,
  output logic        yanit_hata_o,
  input  logic        emekli_i,
  input  logic        fpu_bayrak_gecerli_i,
  input  logic [4:0]  fpu_bayrak_i,
  input  logic        fp_kirlet_i,
  input  logic        istisna_i,
  input  logic [31:0] istisna_pc_i,
  input  logic [31:0] istisna_neden_i,
  input  logic [31:0] istisna_deger_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [2:0]  frm_o,
  output logic [1:0]  fs_o
);

  localparam logic [31:0] MTVEC_RESET_HIZALI = MTVEC_RESET & ~32'h3;

  typedef enum logic {BOSTA, YANIT} durum_t;

  durum_t durum_q, durum_d;

  logic        mstatus_mie_q, mstatus_mpie_q;
  fs_t         fs_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcountinhibit_q;
  logic [2:0]  frm_q;
  logic [4:0]  fflags_q;
  logic [63:0] mcycle_deger, minstret_deger;

  logic [31:0] yanit_veri_q;
  logic        yanit_hata_q;

  csr_yazilabilir_hedef_t hedef;
  logic [31:0] mstatus_oku, eski_deger, yeni_deger;
  logic        yazma_var, kabul, yaz, gecersiz, fp_yaz;

  assign hedef    = csr_hedef_coz(istek_adres_i);
  assign gecersiz = (hedef == CSR_GECERSIZ_HEDEF);

  // Request/response handshake state.
  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  // Accept only when idle and no trap/mret is committing; hold the response until taken.
  always_comb begin
    durum_d         = durum_q;
    istek_hazir_o   = 1'b0;
    yanit_gecerli_o = 1'b0;
    case (durum_q)
      BOSTA: begin
        istek_hazir_o = !istisna_i && !mret_i && !rst_i;
        if (istek_gecerli_i && istek_hazir_o) durum_d = YANIT;
      end
      YANIT: begin
        yanit_gecerli_o = 1'b1;
        if (yanit_hazir_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  assign kabul = istek_gecerli_i && istek_hazir_o;

  // Architectural view of mstatus; MPP is hardwired to machine mode.
  always_comb begin
    mstatus_oku                        = '0;
    mstatus_oku[MSTATUS_MIE]           = mstatus_mie_q;
    mstatus_oku[MSTATUS_MPIE]          = mstatus_mpie_q;
    mstatus_oku[MSTATUS_MPP_LSB +: 2]  = 2'b11;
    mstatus_oku[MSTATUS_FS_LSB +: 2]   = fs_t_deger(fs_q);
    mstatus_oku[MSTATUS_SD]            = (fs_q == FS_KIRLI);
  end

  // Read mux: value of the addressed CSR before this access.
  always_comb begin
    eski_deger = '0;
    case (hedef)
      CSR_FFLAGS_HEDEF:        eski_deger = {27'b0, fflags_q};
      CSR_FRM_HEDEF:           eski_deger = {29'b0, frm_q};
      CSR_FCSR_HEDEF:          eski_deger = {24'b0, frm_q, fflags_q};
      CSR_MSTATUS_HEDEF:       eski_deger = mstatus_oku;
      CSR_MISA_HEDEF:          eski_deger = MISA_DEGER;
      CSR_MIE_HEDEF:           eski_deger = mie_q;
      CSR_MTVEC_HEDEF:         eski_deger = mtvec_q;
      CSR_MCOUNTINHIBIT_HEDEF: eski_deger = mcountinhibit_q;
      CSR_MSCRATCH_HEDEF:      eski_deger = mscratch_q;
      CSR_MEPC_HEDEF:          eski_deger = mepc_q;
      CSR_MCAUSE_HEDEF:        eski_deger = mcause_q;
      CSR_MTVAL_HEDEF:         eski_deger = mtval_q;
      CSR_MCYCLE_HEDEF:        eski_deger = mcycle_deger[31:0];
      CSR_MCYCLEH_HEDEF:       eski_deger = mcycle_deger[63:32];
      CSR_MINSTRET_HEDEF:      eski_deger = minstret_deger[31:0];
      CSR_MINSTRETH_HEDEF:     eski_deger = minstret_deger[63:32];
      default:                 eski_deger = '0;
    endcase
  end

  // Operation decode; set/clear with a zero operand is a pure read.
  always_comb begin
    yazma_var  = 1'b0;
    yeni_deger = istek_veri_i;
    case (csr_islem_t'(istek_islem_i))
      CSR_RW: begin
        yazma_var  = 1'b1;
        yeni_deger = istek_veri_i;
      end
      CSR_RS: begin
        yazma_var  = |istek_veri_i;
        yeni_deger = eski_deger | istek_veri_i;
      end
      CSR_RC: begin
        yazma_var  = |istek_veri_i;
        yeni_deger = eski_deger & ~istek_veri_i;
      end
      default: yazma_var = 1'b0;
    endcase
  end

  assign yaz    = kabul && yazma_var && !gecersiz;
  assign fp_yaz = yaz && (hedef == CSR_FFLAGS_HEDEF || hedef == CSR_FRM_HEDEF ||
                          hedef == CSR_FCSR_HEDEF);

  // Response capture at acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yanit_veri_q <= '0;
      yanit_hata_q <= 1'b0;
    end else if (kabul) begin
      yanit_veri_q <= gecersiz ? '0 : eski_deger;
      yanit_hata_q <= gecersiz;
    end
  end

  // Interrupt-enable stack: trap pushes, mret pops, CSR write otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (istisna_i) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (yaz && hedef == CSR_MSTATUS_HEDEF) begin
      mstatus_mie_q  <= yeni_deger[MSTATUS_MIE];
      mstatus_mpie_q <= yeni_deger[MSTATUS_MPIE];
    end
  end

  // FP state tracking: any FP register or FP CSR update marks it dirty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fs_q <= FS_KAPALI;
    end else if (fp_kirlet_i || fp_yaz) begin
      fs_q <= FS_KIRLI;
    end else if (yaz && hedef == CSR_MSTATUS_HEDEF) begin
      fs_q <= deger_fs_t(yeni_deger[MSTATUS_FS_LSB +: 2]);
    end
  end

  // Rounding mode and sticky exception flags; FPU flags are OR-ed in after any write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frm_q    <= '0;
      fflags_q <= '0;
    end else begin
      if (yaz && hedef == CSR_FRM_HEDEF)       frm_q <= yeni_deger[2:0];
      else if (yaz && hedef == CSR_FCSR_HEDEF) frm_q <= yeni_deger[7:5];
      fflags_q <= ((yaz && (hedef == CSR_FFLAGS_HEDEF || hedef == CSR_FCSR_HEDEF))
                   ? yeni_deger[4:0] : fflags_q)
                  | (fpu_bayrak_gecerli_i ? fpu_bayrak_i : 5'b0);
    end
  end

  // Trap capture registers; trap entry overrides software writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (istisna_i) begin
      mepc_q   <= istisna_pc_i & ~32'h1;
      mcause_q <= istisna_neden_i;
      mtval_q  <= istisna_deger_i;
    end else begin
      if (yaz && hedef == CSR_MEPC_HEDEF)   mepc_q   <= yeni_deger & ~32'h1;
      if (yaz && hedef == CSR_MCAUSE_HEDEF) mcause_q <= yeni_deger;
      if (yaz && hedef == CSR_MTVAL_HEDEF)  mtval_q  <= yeni_deger;
    end
  end

  // Plain software-written registers with their legal-bit masks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q           <= '0;
      mtvec_q         <= MTVEC_RESET_HIZALI;
      mscratch_q      <= '0;
      mcountinhibit_q <= '0;
    end else begin
      if (yaz && hedef == CSR_MIE_HEDEF)           mie_q           <= yeni_deger & MIE_MASKE;
      if (yaz && hedef == CSR_MTVEC_HEDEF)         mtvec_q         <= yeni_deger & ~32'h3;
      if (yaz && hedef == CSR_MSCRATCH_HEDEF)      mscratch_q      <= yeni_deger;
      if (yaz && hedef == CSR_MCOUNTINHIBIT_HEDEF) mcountinhibit_q <= yeni_deger & MCOUNTINHIBIT_MASKE;
    end
  end

`ifdef CSR_SAYACLAR_EN
  csr_sayac u_mcycle (
    .clk      (clk_i),
    .rst      (rst_i),
    .durdur   (mcountinhibit_q[0]),
    .artir    (1'b1),
    .yaz_alt  (yaz && hedef == CSR_MCYCLE_HEDEF),
    .yaz_ust  (yaz && hedef == CSR_MCYCLEH_HEDEF),
    .yaz_veri (yeni_deger),
    .deger    (mcycle_deger)
  );

  csr_sayac u_minstret (
    .clk      (clk_i),
    .rst      (rst_i),
    .durdur   (mcountinhibit_q[2]),
    .artir    (emekli_i),
    .yaz_alt  (yaz && hedef == CSR_MINSTRET_HEDEF),
    .yaz_ust  (yaz && hedef == CSR_MINSTRETH_HEDEF),
    .yaz_veri (yeni_deger),
    .deger    (minstret_deger)
  );
`else
  assign mcycle_deger   = '0;
  assign minstret_deger = '0;
  logic unused_emekli;
  assign unused_emekli = emekli_i;
`endif

  assign yanit_veri_o = yanit_veri_q;
  assign yanit_hata_o = yanit_hata_q;
  assign mtvec_o      = mtvec_q;
  assign mepc_o       = mepc_q;
  assign frm_o        = frm_q;
  assign fs_o         = fs_t_deger(fs_q);

endmodule

// File: tb/tb_csr_dosyasi.sv
// tb/tb_csr_dosyasi.sv - bench for csr_dosyasi: reference model, per-cycle compare, directed and random stimulus
module tb_csr_dosyasi;

`ifdef CSR_SAYACLAR_EN
  localparam bit SAYAC_VAR = 1'b1;
`else
  localparam bit SAYAC_VAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        istek_gecerli = 1'b0, istek_hazir;
  logic [1:0]  islem = '0;
  logic [11:0] adres = '0;
  logic [31:0] veri = '0;
  logic        yanit_gecerli, yanit_hazir = 1'b1, yanit_hata;
  logic [31:0] yanit_veri;
  logic        emekli = 1'b0, bayrak_gecerli = 1'b0, fp_kirlet = 1'b0;
  logic [4:0]  bayrak = '0;
  logic        istisna = 1'b0, mret = 1'b0;
  logic [31:0] ist_pc = '0, ist_neden = '0, ist_deger = '0;
  logic [31:0] mtvec, mepc;
  logic [2:0]  frm;
  logic [1:0]  fs;

  always #5 clk = ~clk;

  csr_dosyasi dut (
    .clk_i(clk), .rst_i(rst),
    .istek_gecerli_i(istek_gecerli), .istek_hazir_o(istek_hazir),
    .istek_islem_i(islem), .istek_adres_i(adres), .istek_veri_i(veri),
    .yanit_gecerli_o(yanit_gecerli), .yanit_hazir_i(yanit_hazir),
    .yanit_veri_o(yanit_veri), .yanit_hata_o(yanit_hata),
    .emekli_i(emekli), .fpu_bayrak_gecerli_i(bayrak_gecerli), .fpu_bayrak_i(bayrak),
    .fp_kirlet_i(fp_kirlet), .istisna_i(istisna), .istisna_pc_i(ist_pc),
    .istisna_neden_i(ist_neden), .istisna_deger_i(ist_deger), .mret_i(mret),
    .mtvec_o(mtvec), .mepc_o(mepc), .frm_o(frm), .fs_o(fs)
  );

  int toplam = 0;
  int hatali = 0;
  bit izle = 1'b0;

  function automatic void kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hatali++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", ad, gercek, beklenen, $time);
    end
  endfunction

  // Reference model: architectural CSR contents plus "response outstanding" flag.
  logic        m_mie, m_mpie, m_bekliyor, m_hata;
  logic [1:0]  m_fs;
  logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_minh, m_veri;
  logic [2:0]  m_frm;
  logic [4:0]  m_fflags;
  logic [63:0] m_mcycle, m_minstret;
  logic        cyc_yazildi, ins_yazildi, fp_yazildi;

  task automatic m_sifirla();
    m_mie = 0; m_mpie = 0; m_fs = 0; m_mier = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_minh = 0; m_frm = 0; m_fflags = 0;
    m_mcycle = 0; m_minstret = 0; m_bekliyor = 0; m_veri = 0; m_hata = 0;
  endtask

  task automatic m_oku(input logic [11:0] a, output logic ok, output logic [31:0] d);
    ok = 1'b1;
    d  = 32'h0;
    case (a)
      12'h001: d = 32'(m_fflags);
      12'h002: d = 32'(m_frm);
      12'h003: d = 32'(m_frm) * 32 + 32'(m_fflags);
      12'h300: d = (32'(m_mie) << 3) | (32'(m_mpie) << 7) | (32'h3 << 11) |
                   (32'(m_fs) << 13) | ((m_fs == 2'b11) ? 32'h8000_0000 : 32'h0);
      12'h301: d = 32'h4000_1124;
      12'h304: d = m_mier;
      12'h305: d = m_mtvec;
      12'h310: d = 32'h0;
      12'h320: d = m_minh;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'hB00: d = SAYAC_VAR ? m_mcycle[31:0] : 32'h0;
      12'hB80: d = SAYAC_VAR ? m_mcycle[63:32] : 32'h0;
      12'hB02: d = SAYAC_VAR ? m_minstret[31:0] : 32'h0;
      12'hB82: d = SAYAC_VAR ? m_minstret[63:32] : 32'h0;
      default: ok = 1'b0;
    endcase
  endtask

  task automatic m_yaz(input logic [11:0] a, input logic [31:0] w);
    case (a)
      12'h001: begin m_fflags = w[4:0]; fp_yazildi = 1; end
      12'h002: begin m_frm = w[2:0]; fp_yazildi = 1; end
      12'h003: begin m_frm = w[7:5]; m_fflags = w[4:0]; fp_yazildi = 1; end
      12'h300: begin m_mie = w[3]; m_mpie = w[7]; m_fs = (w[14:13] == 2'b11) ? 2'b11 : 2'b00; end
      12'h304: m_mier = w & 32'h888;
      12'h305: m_mtvec = w & 32'hFFFF_FFFC;
      12'h320: m_minh = w & 32'h5;
      12'h340: m_mscratch = w;
      12'h341: m_mepc = w & 32'hFFFF_FFFE;
      12'h342: m_mcause = w;
      12'h343: m_mtval = w;
      12'hB00: begin m_mcycle[31:0] = w; cyc_yazildi = 1; end
      12'hB80: begin m_mcycle[63:32] = w; cyc_yazildi = 1; end
      12'hB02: begin m_minstret[31:0] = w; ins_yazildi = 1; end
      12'hB82: begin m_minstret[63:32] = w; ins_yazildi = 1; end
      default: ;
    endcase
  endtask

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_adim();
    logic ok, yazilir;
    logic [31:0] eski, w, inh_eski;
    if (rst) begin
      m_sifirla();
      return;
    end
    inh_eski = m_minh;
    cyc_yazildi = 0; ins_yazildi = 0; fp_yazildi = 0;
    if (istek_gecerli && !m_bekliyor && !istisna && !mret) begin
      m_oku(adres, ok, eski);
      yazilir = (islem == 2'b01) || (islem != 2'b00 && veri != 0);
      w = (islem == 2'b10) ? (eski | veri) : (islem == 2'b11) ? (eski & ~veri) : veri;
      if (ok && yazilir) m_yaz(adres, w);
      m_bekliyor = 1;
      m_veri = ok ? eski : 32'h0;
      m_hata = !ok;
    end else if (m_bekliyor && yanit_hazir) begin
      m_bekliyor = 0;
    end
    if (bayrak_gecerli) m_fflags = m_fflags | bayrak;
    if (fp_kirlet || fp_yazildi) m_fs = 2'b11;
    if (istisna) begin
      m_mepc = ist_pc & 32'hFFFF_FFFE; m_mcause = ist_neden; m_mtval = ist_deger;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end
    if (!cyc_yazildi && !inh_eski[0]) m_mcycle = m_mcycle + 1;
    if (!ins_yazildi && emekli && !inh_eski[2]) m_minstret = m_minstret + 1;
  endtask

  logic        son_kabul = 0, son_yanit = 0, son_hata = 0;
  logic [31:0] son_veri = 0;

  // Compare process: checks every output against the model once per cycle, then advances the model.
  always @(negedge clk) begin
    if (izle) begin
      kontrol("istek_hazir", istek_hazir, !rst && !m_bekliyor && !istisna && !mret);
      kontrol("yanit_gecerli", yanit_gecerli, m_bekliyor);
      if (m_bekliyor) begin
        kontrol("yanit_veri", yanit_veri, m_veri);
        kontrol("yanit_hata", yanit_hata, m_hata);
      end
      kontrol("mtvec_o", mtvec, m_mtvec);
      kontrol("mepc_o", mepc, m_mepc);
      kontrol("frm_o", frm, m_frm);
      kontrol("fs_o", fs, m_fs);
    end
    son_kabul = istek_gecerli && istek_hazir;
    son_yanit = yanit_gecerli && yanit_hazir;
    son_veri  = yanit_veri;
    son_hata  = yanit_hata;
    model_adim();
  end

  task automatic bir_saat();
    @(posedge clk);
    #1;
  endtask

  task automatic istek_gonder(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v);
    int n = 0;
    istek_gecerli = 1; adres = a; islem = op; veri = v;
    do begin bir_saat(); n++; end while (!son_kabul && n < 20);
    istek_gecerli = 0;
    kontrol("kabul_suresi", son_kabul, 1);
  endtask

  task automatic yanit_al(output logic [31:0] d, output logic h);
    int n = 0;
    yanit_hazir = 1;
    do begin bir_saat(); n++; end while (!son_yanit && n < 20);
    kontrol("yanit_suresi", son_yanit, 1);
    d = son_veri;
    h = son_hata;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v,
                     output logic [31:0] d, output logic h);
    istek_gonder(a, op, v);
    yanit_al(d, h);
  endtask

  task automatic sifirla();
    rst = 1; bir_saat(); bir_saat(); rst = 0;
  endtask

  logic [11:0] adresler [0:19] = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h301, 12'h304,
                                   12'h305, 12'h310, 12'h320, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7FF,
                                   12'hC00, 12'h123};

  initial begin
    logic [31:0] d;
    logic h;
    bir_saat(); bir_saat();
    izle = 1;
    // Reset values while reset is still asserted.
    kontrol("rst_hazir", istek_hazir, 0);
    kontrol("rst_gecerli", yanit_gecerli, 0);
    kontrol("rst_veri", yanit_veri, 0);
    kontrol("rst_hata", yanit_hata, 0);
    kontrol("rst_mtvec", mtvec, 0);
    kontrol("rst_mepc", mepc, 0);
    kontrol("rst_frm", frm, 0);
    kontrol("rst_fs", fs, 0);
    rst = 0;
    bir_saat();

    // 1: mscratch write/read; set/clear with zero operand does not write.
    csr(12'h340, 2'b01, 32'hDEADBEEF, d, h);
    kontrol("t1_rw_eski", d, 32'h0);
    csr(12'h340, 2'b10, 32'h0, d, h);
    kontrol("t1_rs_veri", d, 32'hDEADBEEF);
    csr(12'h001, 2'b11, 32'h0, d, h);
    kontrol("t1_rc0_fs", fs, 2'b00);
    csr(12'h301, 2'b01, 32'h0, d, h);
    kontrol("t1_misa", d, 32'h4000_1124);
    kontrol("t1_misa_hata", h, 0);

    // 2: illegal address; response held while not taken.
    yanit_hazir = 0;
    istek_gonder(12'h7FF, 2'b01, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      kontrol("t2_gecerli", yanit_gecerli, 1);
      kontrol("t2_hata", yanit_hata, 1);
      kontrol("t2_veri", yanit_veri, 0);
      kontrol("t2_hazir", istek_hazir, 0);
      bir_saat();
    end
    yanit_al(d, h);

    // Reset during a pending response drops it.
    yanit_hazir = 0;
    istek_gonder(12'h340, 2'b00, 32'h0);
    rst = 1; bir_saat(); rst = 0;
    kontrol("rst_yanit_dus", yanit_gecerli, 0);
    yanit_hazir = 1;
    bir_saat();

    // 3: mcycle carry into mcycleh, then inhibit.
    csr(12'hB80, 2'b01, 32'h0, d, h);
    csr(12'hB00, 2'b01, 32'hFFFF_FFFF, d, h);
    csr(12'hB00, 2'b10, 32'h0, d, h);
    kontrol("t3_mcycle", d, 32'h0);
    csr(12'hB80, 2'b10, 32'h0, d, h);
    kontrol("t3_mcycleh", d, SAYAC_VAR ? 32'h1 : 32'h0);
    csr(12'h320, 2'b01, 32'h1, d, h);
    csr(12'hB00, 2'b01, 32'h100, d, h);
    for (int i = 0; i < 5; i++) bir_saat();
    csr(12'hB00, 2'b10, 32'h0, d, h);
    kontrol("t3_donuk", d, SAYAC_VAR ? 32'h100 : 32'h0);

    // 4: fflags write merged with concurrent FPU flags.
    bayrak = 5'b10000; bayrak_gecerli = 1;
    istek_gonder(12'h001, 2'b01, 32'h1);
    bayrak_gecerli = 0;
    yanit_al(d, h);
    csr(12'h001, 2'b10, 32'h0, d, h);
    kontrol("t4_fflags", d, 32'h11);
    kontrol("t4_fs", fs, 2'b11);
    csr(12'h300, 2'b10, 32'h0, d, h);
    kontrol("t4_sd", d[31], 1);

    // 5: trap entry blocks the request, then mret.
    sifirla();
    csr(12'h300, 2'b01, 32'h8, d, h);
    istek_gecerli = 1; adres = 12'h340; islem = 2'b00; veri = 0;
    istisna = 1; ist_pc = 32'h103; ist_neden = 32'h2; ist_deger = 32'h55;
    #1;
    kontrol("t5_hazir", istek_hazir, 0);
    bir_saat();
    kontrol("t5_kabul", son_kabul, 0);
    istisna = 0; istek_gecerli = 0;
    kontrol("t5_mepc", mepc, 32'h102);
    csr(12'h300, 2'b10, 32'h0, d, h);
    kontrol("t5_mstatus", d, 32'h1880);
    csr(12'h342, 2'b10, 32'h0, d, h);
    kontrol("t5_mcause", d, 32'h2);
    mret = 1; bir_saat(); mret = 0;
    csr(12'h300, 2'b10, 32'h0, d, h);
    kontrol("t5_mret", d, 32'h1888);

    // 6: field masks.
    csr(12'h300, 2'b01, 32'h2000, d, h);
    kontrol("t6_fs", fs, 2'b00);
    csr(12'h300, 2'b10, 32'h0, d, h);
    kontrol("t6_mstatus", d, 32'h1800);
    csr(12'h305, 2'b01, 32'h8000_0003, d, h);
    kontrol("t6_mtvec", mtvec, 32'h8000_0000);
    csr(12'h304, 2'b01, 32'hFFFF_FFFF, d, h);
    csr(12'h304, 2'b10, 32'h0, d, h);
    kontrol("t6_mie", d, 32'h888);
    csr(12'h320, 2'b01, 32'hFFFF_FFFF, d, h);
    csr(12'h320, 2'b10, 32'h0, d, h);
    kontrol("t6_minh", d, 32'h5);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int secim;
      rst = ($urandom_range(0, 299) == 0);
      istek_gecerli = $urandom_range(0, 1);
      islem = 2'($urandom_range(0, 3));
      adres = adresler[$urandom_range(0, 19)];
      secim = $urandom_range(0, 3);
      veri = (secim == 0) ? 32'h0 : (secim == 1) ? 32'hFFFF_FFFF : $urandom;
      yanit_hazir = ($urandom_range(0, 3) != 0);
      emekli = $urandom_range(0, 1);
      bayrak_gecerli = ($urandom_range(0, 3) == 0);
      bayrak = 5'($urandom);
      fp_kirlet = ($urandom_range(0, 15) == 0);
      istisna = ($urandom_range(0, 15) == 0);
      ist_pc = $urandom; ist_neden = $urandom; ist_deger = $urandom;
      mret = ($urandom_range(0, 15) == 0);
      bir_saat();
    end

    $display("test done: total=%0d bad=%0d", toplam, hatali);
    $finish;
  end

endmodule
